// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: state codes, opcodes and datapath mux selects.
// Optional build macro ILLEGAL_TRAP_EN makes the TRAP state reachable.
package ctrl_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXECR  = 4'd6;
    localparam logic [3:0] ST_EXECI  = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BEQ    = 4'd9;
    localparam logic [3:0] ST_JAL    = 4'd10;
    localparam logic [3:0] ST_TRAP   = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_MEMADR = ST_MEMADR,
        S_MEMRD  = ST_MEMRD,
        S_MEMWB  = ST_MEMWB,
        S_MEMWR  = ST_MEMWR,
        S_EXECR  = ST_EXECR,
        S_EXECI  = ST_EXECI,
        S_ALUWB  = ST_ALUWB,
        S_BEQ    = ST_BEQ,
        S_JAL    = ST_JAL,
        S_TRAP   = ST_TRAP
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format follows the opcode alone; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, cleared asynchronously by rst_n.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with one shared memory port and a retire counter.
// Build macro ILLEGAL_TRAP_EN adds the sticky 'illegal' output and a TRAP state left only by reset.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory answers
// DECODE | compute branch target OldPC+imm, dispatch on opcode
// MEMADR | rs1+imm address for lw/sw
// MEMRD  | load access, wait for mem_ready
// MEMWB  | write loaded data to rd
// MEMWR  | store access, wait for mem_ready
// EXECR  | rs1 op rs2
// EXECI  | rs1 op imm
// ALUWB  | write ALUOut to rd
// BEQ    | compare rs1/rs2, take branch on zero
// JAL    | PC <= target, ALUOut <= OldPC+4
// TRAP   | illegal opcode seen, idle until reset
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OP_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [CNT_W-1:0] instret
);

    state_e state_q;
    state_e state_d;

    logic       retire;
    logic       mem_req_c;
    logic       mem_write_c;
    logic       adr_src_c;
    logic       ir_write_c;
    logic       pc_update_c;
    logic       branch_c;
    logic       reg_write_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic       trap_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_update_c  = 1'b0;
        branch_c     = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        alu_op_c     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_a_c  = SRCA_PC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURES;
                ir_write_c   = mem_ready;
                pc_update_c  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op == OP_R) begin
                    state_d = S_EXECR;
                end else if (op == OP_I) begin
                    state_d = S_EXECI;
                end else if (op == OP_BEQ) begin
                    state_d = S_BEQ;
                end else if (op == OP_JAL) begin
                    state_d = S_JAL;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    // Unknown opcode behaves as a NOP and does not retire.
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_d     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_c = RES_MEM;
                reg_write_c  = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALUOP_SUB;
                branch_c    = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_FOUR;
                pc_update_c = 1'b1;
                state_d     = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_d == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal     = illegal_q;
    assign trap_active = (state_q == S_TRAP);
`else
    assign trap_active = 1'b0;
`endif

    // Every output is forced low while reset is held, independent of the clock.
    assign mem_req   = rst_n & mem_req_c;
    assign MemWrite  = rst_n & mem_write_c;
    assign AdrSrc    = rst_n & adr_src_c;
    assign IRWrite   = rst_n & ir_write_c;
    assign PCWrite   = rst_n & (pc_update_c | (branch_c & zero));
    assign RegWrite  = rst_n & reg_write_c;
    assign ResultSrc = {2{rst_n}} & result_src_c;
    assign ALUSrcA   = {2{rst_n}} & alu_src_a_c;
    assign ALUSrcB   = {2{rst_n}} & alu_src_b_c;
    assign ALUOp     = {2{rst_n}} & alu_op_c;
    assign ImmSrc    = (rst_n && !trap_active) ? imm_src_of(op) : IMM_I;

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (retire),
        .count_o(instret)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues random instructions and queues the expected
// per-cycle control word; a negedge monitor pops and compares. Define ILLEGAL_TRAP_EN to test the trap build.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                      P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_TRAP} ph_e;
    typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_e;

    typedef struct packed {
        logic             mem_req;
        logic             MemWrite;
        logic             AdrSrc;
        logic             IRWrite;
        logic             PCWrite;
        logic             RegWrite;
        logic [1:0]       ResultSrc;
        logic [1:0]       ALUSrcA;
        logic [1:0]       ALUSrcB;
        logic [1:0]       ALUOp;
        logic [1:0]       ImmSrc;
        logic             illegal;
        logic [CNT_W-1:0] instret;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       op = 7'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic             illegal_w;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl #(.CNT_W(CNT_W), .OP_W(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .zero     (zero),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .MemWrite (MemWrite),
        .AdrSrc   (AdrSrc),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .ResultSrc(ResultSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .ImmSrc   (ImmSrc),
`ifdef ILLEGAL_TRAP_EN
        .illegal  (illegal_w),
`endif
        .instret  (instret)
    );

`ifndef ILLEGAL_TRAP_EN
    assign illegal_w = 1'b0;
`endif

    always #5 clk = ~clk;

    obs_t        exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned model_ret = 0;
    logic        trap_flag = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o = '{mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
              ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_w, instret};
        return o;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Control word each phase must present, written straight from the phase descriptions.
    function automatic obs_t ctl(input ph_e ph, input logic mr, input logic z);
        obs_t o;
        o = '0;
        o.ImmSrc  = imm_of(op);
        o.instret = model_ret;
        o.illegal = trap_flag;
        case (ph)
            P_FETCH:  begin o.mem_req = 1; o.ALUSrcB = 2'b10; o.ResultSrc = 2'b10;
                            o.IRWrite = mr; o.PCWrite = mr; end
            P_DECODE: begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b01; end
            P_MEMADR: begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; end
            P_MEMRD:  begin o.mem_req = 1; o.AdrSrc = 1; end
            P_MEMWB:  begin o.ResultSrc = 2'b01; o.RegWrite = 1; end
            P_MEMWR:  begin o.mem_req = 1; o.MemWrite = 1; o.AdrSrc = 1; end
            P_EXECR:  begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b00; o.ALUOp = 2'b10; end
            P_EXECI:  begin o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; o.ALUOp = 2'b10; end
            P_ALUWB:  begin o.ResultSrc = 2'b00; o.RegWrite = 1; end
            P_BEQ:    begin o.ALUSrcA = 2'b10; o.ALUOp = 2'b01; o.PCWrite = z; end
            P_JAL:    begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b10; o.PCWrite = 1; end
            P_TRAP:   begin o.ImmSrc = 2'b00; end
            default:  begin end
        endcase
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        obs_t  e;
        string n;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, sample(), e);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input ph_e ph, input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(ctl(ph, mr, z));
        name_q.push_back(ph.name());
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int fw);
        repeat (fw) cyc(P_FETCH, 1'b0, rb());
        cyc(P_FETCH, 1'b1, rb());
    endtask

    task automatic run_instr(input kind_e k, input int fw, input int mw, input logic z);
        logic [6:0] o;
        case (k)
            K_LW:  o = 7'b0000011;
            K_SW:  o = 7'b0100011;
            K_R:   o = 7'b0110011;
            K_I:   o = 7'b0010011;
            K_BEQ: o = 7'b1100011;
            K_JAL: o = 7'b1101111;
            default: begin
                o = 7'h7f;
                if (rb()) begin
                    do o = 7'($urandom); while (is_legal(o));
                end
            end
        endcase
        op = o;
        fetch(fw);
        cyc(P_DECODE, rb(), rb());
        case (k)
            K_LW: begin
                cyc(P_MEMADR, rb(), rb());
                repeat (mw) cyc(P_MEMRD, 1'b0, rb());
                cyc(P_MEMRD, 1'b1, rb());
                cyc(P_MEMWB, rb(), rb());
                model_ret++;
            end
            K_SW: begin
                cyc(P_MEMADR, rb(), rb());
                repeat (mw) cyc(P_MEMWR, 1'b0, rb());
                cyc(P_MEMWR, 1'b1, rb());
                model_ret++;
            end
            K_R: begin
                cyc(P_EXECR, rb(), rb());
                cyc(P_ALUWB, rb(), rb());
                model_ret++;
            end
            K_I: begin
                cyc(P_EXECI, rb(), rb());
                cyc(P_ALUWB, rb(), rb());
                model_ret++;
            end
            K_BEQ: begin
                cyc(P_BEQ, rb(), z);
                model_ret++;
            end
            K_JAL: begin
                cyc(P_JAL, rb(), rb());
                cyc(P_ALUWB, rb(), rb());
                model_ret++;
            end
            default: begin end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kind_e k;
        #1;
        check("reset_outputs", sample(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(K_LW,  0, 0, 1'b0);
        run_instr(K_SW,  0, 3, 1'b0);
        run_instr(K_R,   0, 0, 1'b0);
        run_instr(K_I,   0, 0, 1'b0);
        run_instr(K_BEQ, 1, 0, 1'b1);
        run_instr(K_BEQ, 0, 0, 1'b0);
        run_instr(K_JAL, 0, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        run_instr(K_ILL, 0, 0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_TRAP_EN
            k = kind_e'($urandom_range(0, 5));
`else
            k = kind_e'($urandom_range(0, 6));
`endif
            run_instr(k, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        // Reset asserted in the middle of a jal must clear outputs at once and restart in FETCH.
        op = 7'b1101111;
        fetch(0);
        cyc(P_DECODE, 1'b0, 1'b0);
        mem_ready = 1'b0;
        zero      = 1'b0;
        #1;
        check("jal_pcwrite", sample(), ctl(P_JAL, 1'b0, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_jal", sample(), '0);
        @(posedge clk);
        #1;
        check("reset_hold", sample(), '0);
        rst_n     = 1'b1;
        model_ret = 0;
        run_instr(K_R, 0, 0, 1'b0);
        run_instr(K_SW, 1, 2, 1'b0);

`ifdef ILLEGAL_TRAP_EN
        op = 7'h7f;
        fetch(0);
        cyc(P_DECODE, 1'b0, 1'b0);
        trap_flag = 1'b1;
        repeat (5) cyc(P_TRAP, rb(), rb());
        rst_n = 1'b0;
        #1;
        check("reset_clears_trap", sample(), '0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        trap_flag = 1'b0;
        model_ret = 0;
        run_instr(K_I, 0, 0, 1'b0);
`endif

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
